ping_pong_seg_display: RTL and testbench
========================================

PING_PONG_SEG_DISPLAY -- requirements
Module: ping_pong_seg_display

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high (clk, rst).
REQ-002 SHALL have parameter SCAN_CYCLES, default 100000, clk cycles each digit stays lit, legal range 1..2^20.
REQ-003 SHALL have parameter BLINK_ROUNDS, default 64, full scan rounds of direction blink after a direction change, legal range 1..255.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port load  input  1  capture strobe for value/direction, sampled at clk edge.
REQ-007 SHALL have port value  input  4  ping-pong counter output, 0..15.
REQ-008 SHALL have port direction  input  1  counter direction, 1 = up, 0 = down.
REQ-009 SHALL have port an  output  4  active-low digit enables; an[3] is leftmost.
REQ-010 SHALL have port seg  output  7  active-low segments; seg[0]=a ... seg[6]=g.

Function
REQ-011 SHALL latch val_q<=value and dir_q<=direction at a clk edge with load=1 and rst=0; val_q/dir_q SHALL hold otherwise.
REQ-012 SHALL run a scan counter 0..SCAN_CYCLES-1; at terminal count it wraps to 0 and digit index advances 0->1->2->3->0.
REQ-013 SHALL count one scan round as the terminal count with index=3, i.e. 4*SCAN_CYCLES cycles.
REQ-014 SHALL drive an one-hot-low from index: 0->1110, 1->1101, 2->1011, 3->0111.
REQ-015 SHALL display at digit 0 the ones digit of val_q (val_q mod 10).
REQ-016 SHALL display at digit 1 the digit "1" when val_q>=10; otherwise digit 1 is blank (seg=1111111).
REQ-017 SHALL display at digits 3 and 2 the same direction glyph: dir_q=1 lights a,b,f; dir_q=0 lights c,d,e.
REQ-018 SHALL use standard decimal glyphs, active-low (e.g. 0 = 1000000, 1 = 1111001, 5 = 0010010, 8 = 0000000).
REQ-019 SHALL load blink_cnt<=BLINK_ROUNDS when load=1 and direction!=dir_q, including while blink_cnt is already nonzero (restart).
REQ-020 SHALL leave blink_cnt unaffected by a load with direction==dir_q.
REQ-021 SHALL decrement blink_cnt by 1 at each scan-round end while blink_cnt>0, saturating at 0.
REQ-022 SHALL give a reload in the same cycle as a round end priority over the decrement.
REQ-023 SHALL blank digits 3 and 2 while blink_cnt>0 and blink_cnt[3]=1; digits 1 and 0 are never blinked.
REQ-024 SHALL register an and seg; they reflect index/val_q/dir_q/blink_cnt with exactly one cycle latency.
REQ-025 SHALL therefore show a captured value on the active digit at the second clk edge after the load edge.
REQ-026 SHALL NOT start a blink on the first load after reset when direction=1, since it matches the reset dir_q.

Reset
REQ-027 SHALL set, at a clk edge with rst=1: val_q=0, dir_q=1, scan counter=0, index=0, blink_cnt=0, an=1111, seg=1111111.
REQ-028 SHALL give rst priority over load; a load coincident with rst is discarded.
REQ-029 SHALL, at the first edge after rst falls, drive an=1110 and seg=1000000 (digit 0 showing "0").
REQ-030 SHALL, when reset is asserted mid-scan or mid-blink, abandon all progress and restart from the REQ-027 state.

Verification (SCAN_CYCLES=4, BLINK_ROUNDS=2 unless stated)
REQ-031 SHALL cover reset then idle for 16 cycles -> an steps 1110,1101,1011,0111 every 4 cycles; seg per digit = "0", blank, up glyph, up glyph.
REQ-032 SHALL cover load value=13, direction=1 -> digit 0 shows "3" (0110000), digit 1 shows "1", no blink.
REQ-033 SHALL cover load value=7, direction=0 -> blink_cnt=2, digits 3/2 show down glyph (blink_cnt[3]=0), digit 1 blank, digit 0 "7"; blink_cnt reaches 0 after 2 rounds.
REQ-034 SHALL cover BLINK_ROUNDS=12, a direction change, then another direction change after 3 rounds -> digits 3/2 blank while blink_cnt is 12..8; blink_cnt restarts at 12.
REQ-035 SHALL cover load=1 with rst=1, value=9 -> val_q stays 0; rst mid-scan at index=2 -> next edge an=1111, then scan restarts at index 0.
REQ-036 SHALL cover SCAN_CYCLES=1 -> index advances every cycle; an and seg remain consistent with a 1-cycle output lag.

Source files
------------

// File: rtl/ping_pong_seg_display.sv
// ---------------------------------------------------------------------------
// ping_pong_seg_display
//
// Drives a 4-digit, common-anode 7-segment display for a ping-pong counter.
// Digits are multiplexed one at a time:
//   digit 3 (leftmost) and digit 2 : direction glyph (up = a,b,f ; down = c,d,e)
//   digit 1                        : tens digit ("1" when value >= 10, else blank)
//   digit 0 (rightmost)            : ones digit of the value
// After a direction change the direction glyph blinks for BLINK_ROUNDS full
// scan rounds (blank while bit 3 of the remaining round count is set).
//
// Parameters
//   SCAN_CYCLES  : clk cycles each digit stays lit (1 .. 2^20)
//   BLINK_ROUNDS : scan rounds of blinking after a direction change (1 .. 255)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   load      in   capture strobe for value/direction
//   value     in   4-bit counter value, 0..15
//   direction in   1 = counting up, 0 = counting down
//   an        out  active-low digit enables, an[3] leftmost (registered)
//   seg       out  active-low segments, seg[0]=a .. seg[6]=g (registered)
// ---------------------------------------------------------------------------
module ping_pong_seg_display #(
    parameter int unsigned SCAN_CYCLES  = 100000,
    parameter int unsigned BLINK_ROUNDS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] value,
    input  logic       direction,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned       SCAN_W     = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [7:0]        BLINK_INIT = 8'(BLINK_ROUNDS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_UP    = 7'b1011100;  // a, b, f lit
    localparam logic [6:0] SEG_DOWN  = 7'b1100011;  // c, d, e lit

    // Active-low decimal glyphs, bit order g..a.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    logic [3:0]        val_q,   val_d;
    logic              dir_q,   dir_d;
    logic [SCAN_W-1:0] scan_q,  scan_d;
    logic [1:0]        idx_q,   idx_d;
    logic [7:0]        blink_q, blink_d;
    logic [3:0]        an_q,    an_d;
    logic [6:0]        seg_q,   seg_d;

    logic       scan_last;
    logic       round_end;
    logic       dir_blank;
    logic [3:0] ones_digit;

    // One-hot-low digit enable from the current index.
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
        assign an_d[gi] = (idx_q != 2'(gi));
    end

    always_comb begin
        scan_last  = (scan_q == SCAN_LAST);
        round_end  = scan_last && (idx_q == 2'd3);
        // Value never exceeds 15, so a single conditional subtract gives mod 10.
        ones_digit = (val_q >= 4'd10) ? (val_q - 4'd10) : val_q;
        dir_blank  = (blink_q != 8'd0) && blink_q[3];

        scan_d = scan_last ? '0 : (scan_q + SCAN_W'(1));
        idx_d  = scan_last ? (idx_q + 2'd1) : idx_q;

        val_d = load ? value : val_q;
        dir_d = load ? direction : dir_q;

        // A fresh direction change restarts the blink and wins over a
        // coincident round-end decrement.
        blink_d = blink_q;
        if (load && (direction != dir_q)) begin
            blink_d = BLINK_INIT;
        end else if (round_end && (blink_q != 8'd0)) begin
            blink_d = blink_q - 8'd1;
        end

        seg_d = SEG_BLANK;
        case (idx_q)
            2'd0:    seg_d = digit_glyph(ones_digit);
            2'd1:    seg_d = (val_q >= 4'd10) ? digit_glyph(4'd1) : SEG_BLANK;
            default: seg_d = dir_blank ? SEG_BLANK : (dir_q ? SEG_UP : SEG_DOWN);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= 4'd0;
            dir_q   <= 1'b1;
            scan_q  <= '0;
            idx_q   <= 2'd0;
            blink_q <= 8'd0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
        end else begin
            val_q   <= val_d;
            dir_q   <= dir_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_ping_pong_seg_display.sv
// ---------------------------------------------------------------------------
// tb_ping_pong_seg_display
//
// Three instances share one stimulus stream:
//   dut_a : SCAN_CYCLES=4, BLINK_ROUNDS=2
//   dut_b : SCAN_CYCLES=4, BLINK_ROUNDS=12
//   dut_c : SCAN_CYCLES=1, BLINK_ROUNDS=2
// Each instance is compared every cycle against a behavioural model that
// tracks time since reset, the captured value/direction and remaining blink
// rounds. A hand-written vector table checks dut_a directly, and a few
// directed sequences cover the blink restart and mid-scan reset cases.
// ---------------------------------------------------------------------------
module tb_ping_pong_seg_display;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] UP    = 7'b1011100;
    localparam logic [6:0] DN    = 7'b1100011;
    localparam logic [6:0] G0    = 7'b1000000;
    localparam logic [6:0] G1    = 7'b1111001;
    localparam logic [6:0] G3    = 7'b0110000;
    localparam logic [6:0] G7    = 7'b1111000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] value = 4'd0;
    logic       direction = 1'b1;

    logic [3:0] an_a, an_b, an_c;
    logic [6:0] seg_a, seg_b, seg_c;

    always #5 clk = ~clk;

    ping_pong_seg_display #(.SCAN_CYCLES(4), .BLINK_ROUNDS(2)) dut_a (
        .clk(clk), .rst(rst), .load(load), .value(value), .direction(direction),
        .an(an_a), .seg(seg_a));
    ping_pong_seg_display #(.SCAN_CYCLES(4), .BLINK_ROUNDS(12)) dut_b (
        .clk(clk), .rst(rst), .load(load), .value(value), .direction(direction),
        .an(an_b), .seg(seg_b));
    ping_pong_seg_display #(.SCAN_CYCLES(1), .BLINK_ROUNDS(2)) dut_c (
        .clk(clk), .rst(rst), .load(load), .value(value), .direction(direction),
        .an(an_c), .seg(seg_c));

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;   // edges since reset; the next step has pre-state t = tcyc

    // ---------------- behavioural model ----------------
    typedef struct {
        int t;      // cycle position within a scan round
        int val;
        int dir;
        int blink;
    } model_t;

    model_t mdl [3];
    int     sc_p [3] = '{4, 4, 1};
    int     br_p [3] = '{2, 12, 2};

    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    function automatic logic [10:0] render(model_t m, int sc);
        int         idx = (m.t / sc) % 4;
        logic [3:0] a = 4'b1111;
        logic [6:0] s;
        bit         hide = (m.blink > 0) && (((m.blink / 8) % 2) == 1);
        a[idx] = 1'b0;
        if (idx == 0)      s = glyph_tab[m.val % 10];
        else if (idx == 1) s = (m.val >= 10) ? glyph_tab[1] : BLANK;
        else               s = hide ? BLANK : ((m.dir == 1) ? UP : DN);
        return {a, s};
    endfunction

    function automatic model_t advance(model_t m, int sc, int br,
                                       logic l, logic [3:0] v, logic d);
        model_t n = m;
        bit round_end = (m.t % (4 * sc)) == (4 * sc - 1);
        if (l && (int'(d) != m.dir)) n.blink = br;
        else if (round_end && m.blink > 0) n.blink = m.blink - 1;
        if (l) begin
            n.val = int'(v);
            n.dir = int'(d);
        end
        n.t = (m.t + 1) % (4 * sc);
        return n;
    endfunction

    function automatic logic [10:0] dut_out(int i);
        case (i)
            0:       return {an_a, seg_a};
            1:       return {an_b, seg_b};
            default: return {an_c, seg_c};
        endcase
    endfunction

    task automatic check(string name, logic [3:0] an_act, logic [6:0] seg_act,
                         logic [3:0] an_exp, logic [6:0] seg_exp);
        checks++;
        if (an_act !== an_exp || seg_act !== seg_exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b",
                     name, an_act, seg_act, an_exp, seg_exp);
        end
    endtask

    // One clock: drive inputs, clock, then compare all instances to the model.
    task automatic step(input logic r, input logic l, input logic [3:0] v, input logic d);
        logic [10:0] expv [3];
        logic [10:0] got;
        rst = r; load = l; value = v; direction = d;
        for (int i = 0; i < 3; i++)
            expv[i] = r ? {4'b1111, BLANK} : render(mdl[i], sc_p[i]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (r) mdl[i] = '{0, 0, 1, 0};
            else   mdl[i] = advance(mdl[i], sc_p[i], br_p[i], l, v, d);
            got = dut_out(i);
            check($sformatf("model_dut%0d_t%0d", i, tcyc), got[10:7], got[6:0],
                  expv[i][10:7], expv[i][6:0]);
        end
        if (r) tcyc = 0;
        else   tcyc++;
    endtask

    task automatic idle_until(int target);
        while (tcyc < target) step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // ---------------- vector table for dut_a ----------------
    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] value;
        logic       dir;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(logic r, logic l, logic [3:0] v, logic d,
                                logic [3:0] a, logic [6:0] s);
        vec_t e;
        e.rst = r; e.load = l; e.value = v; e.dir = d; e.an = a; e.seg = s;
        vecs.push_back(e);
    endfunction

    function automatic void idle(int n, logic [3:0] a, logic [6:0] s);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, 4'd0, 1'b0, a, s);
    endfunction

    initial begin
        logic [3:0] an_exp;
        logic       r, l;

        for (int i = 0; i < 3; i++) mdl[i] = '{0, 0, 1, 0};

        // Reset with a coincident load (discarded), then one idle round.
        add(1'b1, 1'b1, 4'd9, 1'b0, 4'b1111, BLANK);
        idle(4, 4'b1110, G0);
        idle(4, 4'b1101, BLANK);
        idle(4, 4'b1011, UP);
        idle(4, 4'b0111, UP);
        // Load 13 going up: no blink.
        add(1'b0, 1'b1, 4'd13, 1'b1, 4'b1110, G0);
        idle(3, 4'b1110, G3);
        idle(4, 4'b1101, G1);
        idle(4, 4'b1011, UP);
        idle(4, 4'b0111, UP);
        // Load 7 going down: blink count 2, bit 3 clear so glyph stays lit.
        add(1'b0, 1'b1, 4'd7, 1'b0, 4'b1110, G3);
        idle(3, 4'b1110, G7);
        idle(4, 4'b1101, BLANK);
        idle(4, 4'b1011, DN);
        idle(4, 4'b0111, DN);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].rst, vecs[k].load, vecs[k].value, vecs[k].dir);
            check($sformatf("vec%0d", k), an_a, seg_a, vecs[k].an, vecs[k].seg);
        end

        // SCAN_CYCLES=1: index advances every cycle.
        step(1'b1, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0);
            an_exp = 4'b1111;
            an_exp[k] = 1'b0;
            check($sformatf("scan1_idx%0d", k), an_c, seg_c, an_exp,
                  (k == 0) ? G0 : ((k == 1) ? BLANK : UP));
        end

        // Reset asserted while dut_a shows index 2.
        idle_until(9);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        check("rst_mid_scan", an_a, seg_a, 4'b1111, BLANK);
        step(1'b0, 1'b0, 4'd0, 1'b0);
        check("rst_restart", an_a, seg_a, 4'b1110, G0);

        // dut_b blink: change direction, change again after 3 rounds.
        step(1'b1, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 4'd5, 1'b0);                 // t=0, blink=12
        idle_until(8);
        step(1'b0, 1'b0, 4'd0, 1'b0);                 // t=8, index 2
        check("blink_blank", an_b, seg_b, 4'b1011, BLANK);
        idle_until(48);
        step(1'b0, 1'b1, 4'd5, 1'b1);                 // t=48, restart at 12
        idle_until(124);
        step(1'b0, 1'b0, 4'd0, 1'b0);                 // blink=8: still blank
        check("blink_restart", an_b, seg_b, 4'b0111, BLANK);
        idle_until(140);
        step(1'b0, 1'b0, 4'd0, 1'b0);                 // blink=7: visible
        check("blink_visible", an_b, seg_b, 4'b0111, UP);

        // Randomized traffic: frequent loads, then sparse loads so long
        // blinks can run out.
        for (int k = 0; k < 4500; k++) begin
            r = ($urandom_range(0, 499) == 0);
            l = (k < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            step(r, l, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
